// File: rtl/write_controller.sv
// rtl/write_controller.sv - async FIFO write-domain pointer, full/level and overflow logic
module write_controller #(
  parameter int ADDR_W    = 5,
  parameter int PTR_W     = 6,
  parameter int AF_THRESH = 28
) (
  input  logic              clkw,
  input  logic              resetw,
  input  logic              write,
  input  logic              clr_ovf,
  input  logic [PTR_W-1:0]  rptrs,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [PTR_W-1:0]  wptr,
  output logic              fullflag,
  output logic              almost_full,
  output logic [PTR_W-1:0]  wlevel,
  output logic              overflow
);

  localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(AF_THRESH);

  logic [PTR_W-1:0] wbin_q, wbin_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic             fullflag_q, fullflag_d;
  logic             almost_full_q, almost_full_d;
  logic [PTR_W-1:0] wlevel_q, wlevel_d;
  logic             overflow_q, overflow_d;
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] full_match;
  logic             accept;

  // Convert the synchronised Gray read pointer back to binary with an XOR prefix
  always_comb begin
    rbin = '0;
    rbin[PTR_W-1] = rptrs[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ rptrs[i];
    end
  end

  // Next pointer, flags and level; full is computed from the post-accept pointer so it
  // asserts on the same edge that consumes the last free slot
  always_comb begin
    accept        = write & ~fullflag_q;
    full_match    = {~rptrs[PTR_W-1:PTR_W-2], rptrs[PTR_W-3:0]};
    wbin_d        = wbin_q + PTR_W'(accept);
    wptr_d        = wbin_d ^ (wbin_d >> 1);
    fullflag_d    = (wptr_d == full_match);
    wlevel_d      = wbin_d - rbin;
    almost_full_d = (wlevel_d >= AF_LEVEL);
    overflow_d    = overflow_q;
    if (clr_ovf) begin
      overflow_d = 1'b0;
    end
    if (write & fullflag_q) begin
      overflow_d = 1'b1;
    end
  end

  // Write-domain state registers
  always_ff @(posedge clkw or negedge resetw) begin
    if (!resetw) begin
      wbin_q        <= '0;
      wptr_q        <= '0;
      fullflag_q    <= 1'b0;
      almost_full_q <= 1'b0;
      wlevel_q      <= '0;
      overflow_q    <= 1'b0;
    end else begin
      wbin_q        <= wbin_d;
      wptr_q        <= wptr_d;
      fullflag_q    <= fullflag_d;
      almost_full_q <= almost_full_d;
      wlevel_q      <= wlevel_d;
      overflow_q    <= overflow_d;
    end
  end

  assign wen         = accept;
  assign waddr       = wbin_q[ADDR_W-1:0];
  assign wptr        = wptr_q;
  assign fullflag    = fullflag_q;
  assign almost_full = almost_full_q;
  assign wlevel      = wlevel_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_write_controller.sv
// tb/tb_write_controller.sv - directed bench for write_controller
module tb_write_controller;

  logic       clkw;
  logic       resetw;
  logic       write;
  logic       clr_ovf;
  logic [5:0] rptrs;
  logic       wen;
  logic [4:0] waddr;
  logic [5:0] wptr;
  logic       fullflag;
  logic       almost_full;
  logic [5:0] wlevel;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  write_controller #(.ADDR_W(5), .PTR_W(6), .AF_THRESH(28)) dut (
    .clkw(clkw), .resetw(resetw), .write(write), .clr_ovf(clr_ovf), .rptrs(rptrs),
    .wen(wen), .waddr(waddr), .wptr(wptr), .fullflag(fullflag),
    .almost_full(almost_full), .wlevel(wlevel), .overflow(overflow)
  );

  initial clkw = 1'b0;
  always #5 clkw = ~clkw;

  function automatic logic [5:0] gray(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clkw);
    #1;
  endtask

  task automatic do_reset();
    write   = 1'b0;
    clr_ovf = 1'b0;
    rptrs   = 6'd0;
    resetw  = 1'b0;
    #3;
    resetw  = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    write = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (wlevel !== 6'd10) begin
      errors++; $display("FAIL reset_pre_level got %0d want 10", wlevel);
    end
    write = 1'b0;
    #1;
    resetw = 1'b0;
    #1;
    checks++;
    if ({wen, waddr, wptr, fullflag, almost_full, wlevel, overflow} !== 21'd0) begin
      errors++;
      $display("FAIL reset_async got wen=%b waddr=%0d wptr=%b full=%b af=%b lvl=%0d ovf=%b want all 0",
               wen, waddr, wptr, fullflag, almost_full, wlevel, overflow);
    end
    resetw = 1'b1;
    tick();
    checks++;
    if (wptr !== 6'd0 || wlevel !== 6'd0) begin
      errors++; $display("FAIL reset_hold got wptr=%b lvl=%0d want 0 0", wptr, wlevel);
    end
  endtask

  task automatic test_fill();
    do_reset();
    write = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      checks++;
      if (wlevel !== 6'(i) || almost_full !== (i >= 28) || fullflag !== (i == 32)) begin
        errors++;
        $display("FAIL fill_%0d got lvl=%0d af=%b full=%b want lvl=%0d af=%b full=%b",
                 i, wlevel, almost_full, fullflag, i, (i >= 28), (i == 32));
      end
    end
    write = 1'b0;
    checks++;
    if (wptr !== 6'b110000 || waddr !== 5'd0) begin
      errors++; $display("FAIL fill_ptr got wptr=%b waddr=%0d want 110000 0", wptr, waddr);
    end
  endtask

  task automatic test_overflow();
    write = 1'b1;
    #1;
    checks++;
    if (wen !== 1'b0) begin
      errors++; $display("FAIL ovf_wen got %b want 0", wen);
    end
    tick();
    write = 1'b0;
    checks++;
    if (wptr !== 6'b110000 || waddr !== 5'd0 || overflow !== 1'b1 || wlevel !== 6'd32) begin
      errors++;
      $display("FAIL ovf_set got wptr=%b waddr=%0d ovf=%b lvl=%0d want 110000 0 1 32",
               wptr, waddr, overflow, wlevel);
    end
    tick();
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky got %b want 1", overflow);
    end
    write = 1'b1;
    clr_ovf = 1'b1;
    tick();
    write = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set_wins got %b want 1", overflow);
    end
    tick();
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got %b want 0", overflow);
    end
  endtask

  task automatic test_drain();
    rptrs = 6'b000110;
    tick();
    checks++;
    if (fullflag !== 1'b0 || wlevel !== 6'd28 || almost_full !== 1'b1) begin
      errors++;
      $display("FAIL drain_4 got full=%b lvl=%0d af=%b want 0 28 1", fullflag, wlevel, almost_full);
    end
    rptrs = gray(6'd5);
    tick();
    checks++;
    if (fullflag !== 1'b0 || wlevel !== 6'd27 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL drain_5 got full=%b lvl=%0d af=%b want 0 27 0", fullflag, wlevel, almost_full);
    end
  endtask

  task automatic test_wrap();
    logic [5:0] wb;
    int bad_full;
    int bad_level;
    bit saw63;
    bit saw0;
    do_reset();
    write = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    wb = 6'd4;
    bad_full = 0; bad_level = 0; saw63 = 0; saw0 = 0;
    for (int i = 0; i < 70; i++) begin
      rptrs = gray(wb - 6'd3);
      tick();
      wb = wb + 6'd1;
      if (fullflag !== 1'b0) bad_full++;
      if (wlevel !== 6'd4) bad_level++;
      if (wb == 6'd63) begin
        saw63 = 1;
        checks++;
        if (wptr !== 6'b100000) begin
          errors++; $display("FAIL wrap_63 got wptr=%b want 100000", wptr);
        end
      end
      if (wb == 6'd0) begin
        saw0 = 1;
        checks++;
        if (wptr !== 6'b000000 || waddr !== 5'd0) begin
          errors++; $display("FAIL wrap_0 got wptr=%b waddr=%0d want 000000 0", wptr, waddr);
        end
      end
    end
    write = 1'b0;
    checks++;
    if (bad_full != 0 || bad_level != 0 || !saw63 || !saw0) begin
      errors++;
      $display("FAIL wrap_steady got bad_full=%0d bad_level=%0d saw63=%0d saw0=%0d want 0 0 1 1",
               bad_full, bad_level, saw63, saw0);
    end
    checks++;
    if (wptr !== gray(6'd10)) begin
      errors++; $display("FAIL wrap_end got wptr=%b want %b", wptr, gray(6'd10));
    end
  endtask

  task automatic test_coincident();
    do_reset();
    write = 1'b1;
    for (int i = 0; i < 31; i++) tick();
    checks++;
    if (wlevel !== 6'd31 || fullflag !== 1'b0) begin
      errors++; $display("FAIL coin_pre got lvl=%0d full=%b want 31 0", wlevel, fullflag);
    end
    rptrs = gray(6'd1);
    tick();
    write = 1'b0;
    checks++;
    if (fullflag !== 1'b0 || wlevel !== 6'd31 || wptr !== 6'b110000) begin
      errors++;
      $display("FAIL coin_edge got full=%b lvl=%0d wptr=%b want 0 31 110000", fullflag, wlevel, wptr);
    end
  endtask

  initial begin
    resetw  = 1'b0;
    write   = 1'b0;
    clr_ovf = 1'b0;
    rptrs   = 6'd0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_wrap();
    test_coincident();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
